spi_command_handler: RTL and testbench

Byte-level command layer directly downstream of the SPI slave shift stage. It consumes each received byte and its strobe, decodes a command/address header, and then either writes the following bytes into an internal register bank or streams register contents back as the next transmit byte. Registers are exposed to the rest of the design through a write-notify strobe and a registered read port.

---
 rtl/spi_command_handler_if.sv | 28 ++
 rtl/spi_command_handler.sv | 167 ++++++++++++++++
 tb/tb_spi_command_handler.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_command_handler_if.sv
// Byte-level bus between the SPI slave shift stage, the command handler and local register readers.
// Carries the received byte strobe, the transmit byte, the write-notify strobe and the local read port.
// No backpressure: rx_valid is a one-cycle pulse and every output is a registered one-cycle result.
interface spi_command_handler_if #(
    parameter int ADDR_WIDTH = 4
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic [7:0]            tx_data;
    logic                  wr_strobe;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            rd_data;
    logic                  cmd_error;

    // Shift stage / local reader side
    modport master (
        output rx_data, rx_valid, rd_addr,
        input  tx_data, wr_strobe, wr_addr, wr_data, rd_data, cmd_error
    );

    // Command handler side
    modport slave (
        input  rx_data, rx_valid, rd_addr,
        output tx_data, wr_strobe, wr_addr, wr_data, rd_data, cmd_error
    );
endinterface

// File: rtl/spi_command_handler.sv
// Decodes SPI command/address headers and writes to, or streams from, an 8-bit register bank.
// Latency: one clk from rx_valid to tx_data / wr_strobe / cmd_error; one clk for the local read port.
// No backpressure: every rx_valid byte is consumed; an idle gap of TIMEOUT clks abandons the transaction.
module spi_command_handler #(
    parameter int         NUM_REGS   = 16,
    parameter int         ADDR_WIDTH = 4,
    parameter int         TIMEOUT    = 1024,
    parameter logic [7:0] ID_BYTE    = 8'hA5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    spi_command_handler_if.slave io_bus
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DISCARD
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_ptr_inc;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_timeout;
    logic                  w_cmd_oor;
    logic                  w_rd_in_range;
    logic                  w_wr_en;
    logic                  w_err;
    logic [7:0]            w_tx_nxt;

    logic [7:0]            r_regs [NUM_REGS];
    logic [7:0]            r_tx_data;
    logic                  r_wr_strobe;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [7:0]            r_wr_data;
    logic [7:0]            r_rd_data;
    logic                  r_cmd_error;

    // The address field is 7 bits regardless of ADDR_WIDTH, so range-check the full field.
    assign w_cmd_oor     = ({1'b0, io_bus.rx_data[6:0]} >= 8'(NUM_REGS));
    // Pointer wraps at the last implemented register, not at the power-of-two boundary.
    assign w_ptr_inc     = (r_ptr == ADDR_WIDTH'(NUM_REGS - 1)) ? '0 : r_ptr + ADDR_WIDTH'(1);
    assign w_timeout     = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_rd_in_range = ({1'b0, io_bus.rd_addr} < (ADDR_WIDTH + 1)'(NUM_REGS));

    // State, pointer and inactivity counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state decode: a byte arriving on the timeout cycle is processed before the timeout applies
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_wr_en     = 1'b0;
        w_err       = 1'b0;
        w_tx_nxt    = ID_BYTE;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (io_bus.rx_valid) begin
                    if (w_cmd_oor) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_DISCARD;
                    end else begin
                        w_ptr_nxt   = io_bus.rx_data[ADDR_WIDTH-1:0];
                        w_state_nxt = io_bus.rx_data[7] ? S_WRITE : S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (io_bus.rx_valid) begin
                    w_wr_en   = 1'b1;
                    w_ptr_nxt = w_ptr_inc;
                    w_cnt_nxt = '0;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_READ: begin
                if (io_bus.rx_valid) begin
                    w_ptr_nxt = w_ptr_inc;
                    w_cnt_nxt = '0;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_DISCARD: begin
                if (io_bus.rx_valid) begin
                    w_cnt_nxt = '0;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // While reading, the transmit byte tracks the register under the (next) pointer every cycle,
        // so it always shows the live register contents; every other state presents the ID byte.
        if (w_state_nxt == S_READ) begin
            w_tx_nxt = r_regs[w_ptr_nxt];
        end
    end

    // Register bank and write-notify strobe
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_strobe <= w_wr_en;
            if (w_wr_en) begin
                r_regs[r_ptr] <= io_bus.rx_data;
                r_wr_addr     <= r_ptr;
                r_wr_data     <= io_bus.rx_data;
            end
        end
    end

    // Transmit byte, command error pulse and local read port (reads see the pre-write value)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_data   <= ID_BYTE;
            r_cmd_error <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_tx_data   <= w_tx_nxt;
            r_cmd_error <= w_err;
            r_rd_data   <= w_rd_in_range ? r_regs[io_bus.rd_addr] : 8'h00;
        end
    end

    assign io_bus.tx_data   = r_tx_data;
    assign io_bus.wr_strobe = r_wr_strobe;
    assign io_bus.wr_addr   = r_wr_addr;
    assign io_bus.wr_data   = r_wr_data;
    assign io_bus.rd_data   = r_rd_data;
    assign io_bus.cmd_error = r_cmd_error;

endmodule

// File: tb/tb_spi_command_handler.sv
// Self-checking bench for spi_command_handler against a transaction-level reference model.
// Inputs are driven 1 time unit after each rising edge and outputs checked at the same point.
// Byte gaps are chosen by the bench, so timeouts are predicted from the gap length alone.
module tb_spi_command_handler;

    localparam int         NREGS = 16;
    localparam int         AW    = 4;
    localparam int         TO    = 64;
    localparam logic [7:0] IDB   = 8'hA5;

    // Model transaction modes
    localparam int M_IDLE = 0;
    localparam int M_WR   = 1;
    localparam int M_RD   = 2;
    localparam int M_DISC = 3;

    logic clk;
    logic rst;

    spi_command_handler_if #(.ADDR_WIDTH(AW)) bus ();

    spi_command_handler #(
        .NUM_REGS  (NREGS),
        .ADDR_WIDTH(AW),
        .TIMEOUT   (TO),
        .ID_BYTE   (IDB)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Reference model state
    logic [7:0] m_regs [NREGS];
    int         m_mode;
    int         m_ptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One cycle with no byte: random local read, strobes must be quiet
    task automatic idle_tick();
        logic [AW-1:0] a;
        logic [7:0]    exp_rd;
        a           = AW'($urandom_range(NREGS - 1, 0));
        bus.rd_addr = a;
        exp_rd      = m_regs[a];
        @(posedge clk);
        #1;
        chk("rd_idle", bus.rd_data, exp_rd);
        chk("wr_quiet", bus.wr_strobe, 1'b0);
        chk("err_quiet", bus.cmd_error, 1'b0);
    endtask

    // Send one byte after 'gap' idle cycles and check the one-cycle response
    task automatic send(input logic [7:0] b, input int gap);
        logic          exp_wr;
        logic          exp_err;
        logic [AW-1:0] exp_wa;
        logic [AW-1:0] a;
        logic [7:0]    exp_rd;
        logic [7:0]    exp_tx;
        repeat (gap) idle_tick();
        if (gap >= TO) begin
            m_mode = M_IDLE;
            chk("timeout_tx", bus.tx_data, IDB);
        end
        exp_wr  = 1'b0;
        exp_err = 1'b0;
        exp_wa  = AW'(m_ptr);
        // During a write, read the address being written to see the pre-write value
        a      = (m_mode == M_WR) ? AW'(m_ptr) : AW'($urandom_range(NREGS - 1, 0));
        exp_rd = m_regs[a];
        case (m_mode)
            M_IDLE: begin
                if (int'(b[6:0]) >= NREGS) begin
                    exp_err = 1'b1;
                    m_mode  = M_DISC;
                end else begin
                    m_ptr  = int'(b[6:0]);
                    m_mode = b[7] ? M_WR : M_RD;
                end
            end
            M_WR: begin
                exp_wr        = 1'b1;
                m_regs[m_ptr] = b;
                m_ptr         = (m_ptr + 1) % NREGS;
            end
            M_RD:    m_ptr = (m_ptr + 1) % NREGS;
            default: ;
        endcase
        bus.rd_addr  = a;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        chk("wr_strobe", bus.wr_strobe, exp_wr);
        chk("cmd_error", bus.cmd_error, exp_err);
        chk("rd_old", bus.rd_data, exp_rd);
        if (exp_wr) begin
            chk("wr_addr", bus.wr_addr, exp_wa);
            chk("wr_data", bus.wr_data, b);
        end
        if (m_mode != M_WR) begin
            exp_tx = (m_mode == M_RD) ? m_regs[m_ptr] : IDB;
            chk("tx_data", bus.tx_data, exp_tx);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        m_mode = M_IDLE;
        m_ptr  = 0;
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rd_addr  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and full read sweep
        chk("rst_tx", bus.tx_data, IDB);
        chk("rst_wr", bus.wr_strobe, 1'b0);
        chk("rst_err", bus.cmd_error, 1'b0);
        for (int i = 0; i < NREGS; i++) begin
            bus.rd_addr = AW'(i);
            @(posedge clk);
            #1;
            chk("rst_rd", bus.rd_data, 8'h00);
        end

        // Burst write: reg3 = 11, reg4 = 22
        send(8'h83, 2);
        send(8'h11, 3);
        send(8'h22, 2);
        repeat (2) idle_tick();
        bus.rd_addr = AW'(3);
        @(posedge clk);
        #1;
        chk("reg3", bus.rd_data, 8'h11);
        bus.rd_addr = AW'(4);
        @(posedge clk);
        #1;
        chk("reg4", bus.rd_data, 8'h22);

        // Burst write across the wrap, then read stream 14, 15, 0
        send(8'h8E, TO + 2);
        send(8'h5E, 2);
        send(8'h6F, 2);
        send(8'h70, 2);
        send(8'h0E, TO + 1);
        chk("rd14", bus.tx_data, 8'h5E);
        send(8'h00, 2);
        chk("rd15", bus.tx_data, 8'h6F);
        send(8'h00, 2);
        chk("rd0_wrap", bus.tx_data, 8'h70);

        // Out-of-range command, discarded byte, then a clean write after timeout
        send(8'h90, TO + 1);
        send(8'hFF, 2);
        send(8'h81, TO);
        send(8'h33, 2);

        // Byte arriving exactly on the timeout cycle is still data
        send(8'h82, TO + 5);
        send(8'h44, TO - 1);
        // One cycle later it is a new (out-of-range) read command
        send(8'h82, TO + 5);
        send(8'h44, TO);
        chk("late_err_mode", m_mode, M_DISC);

        // Reset between command and data byte
        send(8'h85, TO + 5);
        repeat (2) idle_tick();
        rst = 1'b1;
        #1;
        chk("rst_async_tx", bus.tx_data, IDB);
        chk("rst_async_wr", bus.wr_strobe, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rd_addr = AW'(5);
        @(posedge clk);
        #1;
        chk("reg5_after_rst", bus.rd_data, 8'h00);
        send(8'h12, 2);

        // Randomised transactions
        for (int t = 0; t < 40; t++) begin
            logic [7:0] cmd;
            int         nb;
            cmd = {1'($urandom_range(1, 0)), 7'($urandom_range(NREGS + 4, 0))};
            send(cmd, TO + int'($urandom_range(4, 0)));
            nb = int'($urandom_range(6, 1));
            for (int k = 0; k < nb; k++) begin
                send(8'($urandom), ($urandom_range(7, 0) == 0) ? TO - 1 : int'($urandom_range(6, 2)));
            end
        end
        repeat (TO + 2) idle_tick();
        chk("final_tx", bus.tx_data, IDB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
